// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike rate and inter-spike interval decoder
// Counts spike rising edges per 2**WINDOW_LOG2 cycles and hands results downstream over valid/ready.
module spike_rate_decoder #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             spk,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] rate_out,
  output logic [CNT_W-1:0] isi_out,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

  state_t                 state, state_nxt;
  logic                   spk_q;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [CNT_W-1:0]       spk_cnt;
  logic [CNT_W-1:0]       isi_cnt;
  logic [CNT_W-1:0]       isi_last;
  logic                   have_spk;

  logic                   spk_edge;
  logic                   count_en;
  logic                   win_end;
  logic [CNT_W-1:0]       spk_cnt_inc;
  logic [CNT_W-1:0]       isi_inc;
  logic [CNT_W-1:0]       isi_last_upd;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:    if (en) state_nxt = ARM;
      ARM:     state_nxt = COUNT;
      COUNT: begin
        busy = 1'b1;
        if (!en) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating next values; the window-end result must include this cycle's edge.
  always_comb begin
    spk_edge     = spk & ~spk_q;
    count_en     = (state == COUNT) && en;
    win_end      = count_en && (win_cnt == WIN_LAST);
    spk_cnt_inc  = (spk_edge && (spk_cnt != CNT_MAX)) ? spk_cnt + 1'b1 : spk_cnt;
    isi_inc      = (isi_cnt != CNT_MAX) ? isi_cnt + 1'b1 : isi_cnt;
    isi_last_upd = (spk_edge && have_spk) ? isi_inc : isi_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      spk_q     <= 1'b0;
      win_cnt   <= '0;
      spk_cnt   <= '0;
      isi_cnt   <= '0;
      isi_last  <= '0;
      have_spk  <= 1'b0;
      out_valid <= 1'b0;
      rate_out  <= '0;
      isi_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_nxt;
      spk_q <= spk;

      if (state == ARM) begin
        win_cnt  <= '0;
        spk_cnt  <= '0;
        isi_cnt  <= '0;
        isi_last <= '0;
        have_spk <= 1'b0;
      end else if (count_en) begin
        win_cnt  <= win_cnt + 1'b1;
        spk_cnt  <= win_end ? '0 : spk_cnt_inc;
        isi_cnt  <= spk_edge ? '0 : isi_inc;
        isi_last <= isi_last_upd;
        if (spk_edge) have_spk <= 1'b1;
      end

      // A held, unaccepted result wins over a newer one.
      if (win_end && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        rate_out  <= spk_cnt_inc;
        isi_out   <= isi_last_upd;
      end else if (win_end) begin
        overrun   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - scoreboard bench for spike_rate_decoder
// Timestamp-based reference model predicts results; a separate monitor checks them.
module tb_spike_rate_decoder;

  localparam int WL   = 4;
  localparam int CW   = 3;
  localparam int WIN  = 1 << WL;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          spk = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [CW-1:0] rate_out;
  logic [CW-1:0] isi_out;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;

  spike_rate_decoder #(.WINDOW_LOG2(WL), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .spk       (spk),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .rate_out  (rate_out),
    .isi_out   (isi_out),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 arm, 2 count; spikes tracked by timestamp.
  int m_phase = 0;
  int m_pos = 0;
  int m_wedges = 0;
  int m_last = -1;
  int m_gap = 0;
  int m_t = 0;
  bit m_spk_prev = 0;
  bit m_valid = 0;
  bit m_overrun = 0;
  int exp_rate[$];
  int exp_isi[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit e;
    bit have_res;
    int rr;
    int ii;
    e = spk && !m_spk_prev;
    have_res = 0;
    rr = 0;
    ii = 0;
    if (reset) begin
      m_phase = 0; m_pos = 0; m_wedges = 0; m_last = -1; m_gap = 0;
      m_spk_prev = 0; m_valid = 0; m_overrun = 0;
      exp_rate.delete();
      exp_isi.delete();
    end else begin
      m_spk_prev = spk;
      case (m_phase)
        0: if (en) m_phase = 1;
        1: begin
          m_pos = 0; m_wedges = 0; m_last = -1; m_gap = 0;
          m_phase = 2;
        end
        default: begin
          if (!en) m_phase = 0;
          else begin
            if (e) begin
              m_wedges++;
              if (m_last >= 0) m_gap = (m_t - m_last > MAXC) ? MAXC : m_t - m_last;
              m_last = m_t;
            end
            if (m_pos == WIN - 1) begin
              have_res = 1;
              rr = (m_wedges > MAXC) ? MAXC : m_wedges;
              ii = m_gap;
              m_wedges = 0;
              m_pos = 0;
            end else m_pos++;
          end
        end
      endcase
      if (have_res && (!m_valid || out_ready)) begin
        exp_rate.push_back(rr);
        exp_isi.push_back(ii);
        m_valid = 1;
      end else if (have_res) m_overrun = 1;
      else if (m_valid && out_ready) m_valid = 0;
    end
    m_t++;
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic rd);
    @(negedge clk);
    reset = r; en = e; spk = s; out_ready = rd;
    model_step();
  endtask

  // Monitor: checks control outputs every cycle and pops results on each new presentation.
  bit prev_valid = 0;
  int hold_rate = 0;
  int hold_isi = 0;
  always @(posedge clk) begin
    #1;
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("overrun", int'(overrun), int'(m_overrun));
    chk("busy", int'(busy), int'(m_phase == 2));
    if (out_valid && (!prev_valid || out_ready)) begin
      if (exp_rate.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        hold_rate = exp_rate.pop_front();
        hold_isi  = exp_isi.pop_front();
        chk("rate_out", int'(rate_out), hold_rate);
        chk("isi_out", int'(isi_out), hold_isi);
      end
    end else if (out_valid) begin
      chk("rate_stable", int'(rate_out), hold_rate);
      chk("isi_stable", int'(isi_out), hold_isi);
    end
    prev_valid = out_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with spike line toggling.
    for (int i = 0; i < 3; i++) drive(1, 0, logic'(i % 2), 0);
    drive(0, 0, 0, 1);
    chk("reset_rate", int'(rate_out), 0);
    chk("reset_isi", int'(isi_out), 0);
    chk("reset_valid", int'(out_valid), 0);

    // Periodic 1-cycle pulses every 4 cycles.
    for (int i = 0; i < 5 * WIN; i++) drive(0, 1, logic'(i % 4 == 0), 1);
    // Quiet gap then a long held spike.
    for (int i = 0; i < 20; i++) drive(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) drive(0, 1, 1, 1);
    for (int i = 0; i < 30; i++) drive(0, 1, 0, 1);
    // Fast toggling saturates the rate.
    for (int i = 0; i < 3 * WIN; i++) drive(0, 1, logic'(i % 2), 1);
    // Back-pressure across window ends.
    for (int i = 0; i < 2 * WIN + 8; i++) drive(0, 1, logic'(i % 3 == 0), 0);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 1);
    // Drop enable after three spikes, then re-arm with spike high at en rise.
    for (int i = 0; i < 6; i++) drive(0, 1, logic'(i % 2 == 0), 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 1);
    for (int i = 0; i < 3 * WIN; i++) drive(0, 1, logic'(i % 5 == 0 || i < 3), 1);

    // Randomized traffic with occasional enable drops and a mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      drive(logic'(i == 2000),
            logic'($urandom_range(0, 63) != 0),
            logic'($urandom_range(0, 2) == 0),
            logic'($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1);
    @(negedge clk);
    chk("sb_empty", exp_rate.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
